// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic pipeline stage register with valid/ready handshake,
// a 2-entry skid buffer (main + skid) and a synchronous flush.
// Optional performance counters are built when PIPE_PERF_EN is defined;
// otherwise stall_cnt and bubble_cnt are tied to zero and no counter flops exist.
//
// Handshake: a beat moves upstream->stage when in_valid & in_ready, and
// stage->downstream when out_valid & out_ready, both sampled on the rising
// clock edge. in_ready depends only on registered state (no path from
// out_ready), so stages can be chained without long combinational ready chains.
module pipe_skid_reg #(
  parameter int DATA_W = 71,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              acc;
  logic              fire;

  // Outputs are pure functions of the registered state; occupancy doubles as
  // the FSM debug view.
  assign occupancy = state_q;
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  // Next-state and data-path selection; flush drops every held entry but
  // leaves the data registers untouched so out_data shows a stale value.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc && fire) begin
            main_d  = in_data;
            state_d = ONE;
          end else if (acc) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and data registers; reset clears everything and overrides flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  // Saturating event counters, sampled on the pre-edge out_valid so flush
  // cycles are classified by what the stage presented during that cycle.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
    if (!out_valid && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  // Counter registers; only reset clears them, flush does not.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
